instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 33 +++
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch_buffer.sv | 48 ++++
 rtl/instr_fetch.sv | 129 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: next-PC select encoding, fetch FSM states and the
// RV32I major opcodes that the control unit decodes from opcode_o.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pcsel_e;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory request/response port and the fetch-to-decode
// valid/ready port. master = fetch unit, slave = memory plus decode.
interface instr_fetch_if import fetch_pkg::*;;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

endinterface

// File: rtl/instr_fetch_buffer.sv
// One-entry valid/ready holding register for a fetched instruction and its PC.
// flush_i wins over push and consume so a redirect always empties the slot.
module fetch_buffer import fetch_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  always_comb begin
    valid_d = valid_q;
    if (flush_i)
      valid_d = 1'b0;
    else if (push_i)
      valid_d = 1'b1;
    else if (valid_q && ready_i)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      if (push_i && !flush_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, one-entry output
// buffer, and control-flow redirects that discard stale in-flight responses.
module instr_fetch import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  instr_fetch_if.master      bus,
  input  logic               redirect_valid_i,
  input  logic [1:0]         nextpc_sel_i,
  input  logic               branch_taken_i,
  input  logic [31:0]        target_i,
  output logic               misalign_o
);

  localparam logic [1:0] S_REQ  = FS_REQ;
  localparam logic [1:0] S_WAIT = FS_WAIT;
  localparam logic [1:0] S_HOLD = FS_HOLD;

  logic [1:0]  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        drop_q, drop_d;
  logic        mis_q, mis_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        accept;
  logic        push;
  logic        flush;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  assign redirect = redirect_valid_i &&
                    ((nextpc_sel_i == PC_JAL) || (nextpc_sel_i == PC_JALR) ||
                     ((nextpc_sel_i == PC_BRANCH) && branch_taken_i));
  assign redirect_pc = word_align(target_i);

  // Request is masked during reset so nothing is issued while state is forced.
  assign bus.imem_req_o  = rst_ni && (state_q == S_REQ);
  assign bus.imem_addr_o = fpc_q;
  assign accept          = bus.imem_req_o && bus.imem_ready_i;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    drop_d  = drop_q;
    push    = 1'b0;
    flush   = 1'b0;
    mis_d   = redirect && target_i[1];
    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d = S_WAIT;
          rpc_d   = fpc_q;
          drop_d  = redirect;
          fpc_d   = redirect ? redirect_pc : fpc_q + 32'd4;
        end else if (redirect) begin
          fpc_d = redirect_pc;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          if (drop_q || redirect) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            push    = 1'b1;
            state_d = S_HOLD;
          end
          if (redirect)
            fpc_d = redirect_pc;
        end else if (redirect) begin
          // Response still in flight: remember to throw it away when it lands.
          drop_d = 1'b1;
          fpc_d  = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          flush   = 1'b1;
          state_d = S_REQ;
          fpc_d   = redirect_pc;
        end else if (buf_valid && bus.instr_ready_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_REQ;
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      drop_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      drop_q  <= drop_d;
      mis_q   <= mis_d;
    end
  end

  fetch_buffer u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .flush_i (flush),
    .instr_i (bus.imem_rdata_i),
    .pc_i    (rpc_q),
    .ready_i (bus.instr_ready_i),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  assign bus.instr_valid_o = buf_valid;
  assign bus.instr_o       = buf_instr;
  assign bus.pc_o          = buf_pc;
  assign bus.opcode_o      = buf_instr[6:0];
  assign misalign_o        = mis_q;

endmodule
